// File: rtl/fifo_elastic_pkg.sv
// Shared sizing helpers for the elastic FIFO: pointer/count widths and
// wrap-aware pointer increment for depths that need not be a power of two.
package fifo_elastic_pkg;

   // Pointer width, never below one bit even for tiny depths.
   function automatic int ptr_width(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   // Count must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit compare against the last slot so non-power-of-two depths wrap correctly.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_elastic_if.sv
// Producer/consumer handshake bundle for the elastic FIFO; the FIFO takes
// the slave view, the surrounding logic (or bench) drives the master view.
interface fifo_elastic_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] i_data_in;
   logic             i_write_en;
   logic             i_ready_out;
   logic [WIDTH-1:0] o_data_out;
   logic             o_read_en;
   logic             o_ready_out;

   modport master (
      output i_data_in,
      output i_write_en,
      input  i_ready_out,
      input  o_data_out,
      output o_read_en,
      input  o_ready_out
   );

   modport slave (
      input  i_data_in,
      input  i_write_en,
      output i_ready_out,
      output o_data_out,
      input  o_read_en,
      output o_ready_out
   );
endinterface

// File: rtl/fifo_elastic_ram.sv
// DEPTH x WIDTH register-file storage: one write port, asynchronous read
// port, every entry cleared on reset.
module fifo_elastic_ram
   import fifo_elastic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] word_q [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] word_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_reg <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
               word_reg <= wr_data;
            end
         end

         assign word_q[gi] = word_reg;
      end
   endgenerate

   // Compare-based mux keeps unused address codes (non-power-of-two depth) reading zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_data = word_q[i];
         end
      end
   end

endmodule

// File: rtl/fifo_elastic.sv
// Single-clock first-word-fall-through elastic FIFO with valid/ready handshake.
// Optional FIFO_ELASTIC_FULL_BYPASS_EN lets a write land while full if a pop occurs.
module fifo_elastic
   import fifo_elastic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_elastic_if.slave  bus
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0] wptr_reg,  wptr_next;
   logic [PW-1:0] rptr_reg,  rptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic full;
   logic empty;
   logic wr_ready;
   logic wr_fire;
   logic rd_fire;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

`ifdef FIFO_ELASTIC_FULL_BYPASS_EN
   // A concurrent pop frees the head slot, which is exactly where wptr points when full.
   assign wr_ready = !full || bus.o_read_en;
`else
   assign wr_ready = !full;
`endif

   assign wr_fire = bus.i_write_en && wr_ready;
   assign rd_fire = bus.o_read_en  && !empty;

   always_comb begin
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;

      if (wr_fire) begin
         wptr_next = PW'(ptr_inc(int'(wptr_reg), DEPTH));
      end
      if (rd_fire) begin
         rptr_next = PW'(ptr_inc(int'(rptr_reg), DEPTH));
      end

      unique case ({wr_fire, rd_fire})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
      end
   end

   fifo_elastic_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire),
      .wr_addr (wptr_reg),
      .wr_data (bus.i_data_in),
      .rd_addr (rptr_reg),
      .rd_data (bus.o_data_out)
   );

   assign bus.i_ready_out = wr_ready;
   assign bus.o_ready_out = !empty;

endmodule

// File: tb/tb_fifo_elastic.sv
// Directed bench for fifo_elastic (WIDTH=4, DEPTH=4): reset, fill, overflow,
// drain with concurrent write, pointer wrap, asynchronous reset mid-fill.
module tb_fifo_elastic;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_errors;

   fifo_elastic_if #(.WIDTH(WIDTH)) bus ();

   fifo_elastic #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Advance one edge; sample point sits 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] fill_vals [4];
   logic [WIDTH-1:0] drain_exp [5];

   initial begin
      int n_pop;
      int guard;
      bit wrote8;

      n_checks = 0;
      n_errors = 0;
      fill_vals = '{4'hA, 4'hB, 4'hC, 4'hD};
      drain_exp = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h8};

      bus.i_data_in  = '0;
      bus.i_write_en = 1'b0;
      bus.o_read_en  = 1'b0;
      rst_n          = 1'b0;

      // Reset held, with a write offered that must not be accepted.
      #2;
      bus.i_write_en = 1'b1;
      bus.i_data_in  = 4'h5;
      tick();
      tick();
      check("rst_o_ready", 32'(bus.o_ready_out), 32'd0);
      check("rst_i_ready", 32'(bus.i_ready_out), 32'd1);
      check("rst_o_data",  32'(bus.o_data_out),  32'd0);
      bus.i_write_en = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      $display("reset released");
      check("post_rst_o_ready", 32'(bus.o_ready_out), 32'd0);
      check("post_rst_i_ready", 32'(bus.i_ready_out), 32'd1);

      // Fill a,b,c,d
      for (int i = 0; i < 4; i++) begin
         bus.i_data_in  = fill_vals[i];
         bus.i_write_en = 1'b1;
         tick();
         $display("write %0h", fill_vals[i]);
         check("fill_o_ready", 32'(bus.o_ready_out), 32'd1);
         check("fill_head",    32'(bus.o_data_out),  32'hA);
         check("fill_i_ready", 32'(bus.i_ready_out), (i < 3) ? 32'd1 : 32'd0);
      end

      // Overflow: e dropped
      bus.i_data_in  = 4'hE;
      bus.i_write_en = 1'b1;
      tick();
      $display("write %0h while full (expect drop)", 4'hE);
      bus.i_write_en = 1'b0;
      check("ovf_i_ready", 32'(bus.i_ready_out), 32'd0);
      check("ovf_head",    32'(bus.o_data_out),  32'hA);

      // Drain continuously; inject 8 as soon as space appears
      bus.o_read_en = 1'b1;
      #1;
      n_pop  = 0;
      guard  = 0;
      wrote8 = 1'b0;
      while (n_pop < 5 && guard < 12) begin
         if (bus.o_ready_out) begin
            $display("read %0h", bus.o_data_out);
            check("drain_data", 32'(bus.o_data_out), 32'(drain_exp[n_pop]));
            n_pop++;
         end
         if (!wrote8 && bus.i_ready_out) begin
            bus.i_data_in  = 4'h8;
            bus.i_write_en = 1'b1;
            wrote8         = 1'b1;
            $display("write 8 during drain");
         end else begin
            bus.i_write_en = 1'b0;
         end
         tick();
         guard++;
      end
      bus.i_write_en = 1'b0;
      check("drain_count",   32'(n_pop), 32'd5);
      check("drain_o_ready", 32'(bus.o_ready_out), 32'd0);

      // Read while empty is ignored
      tick();
      $display("read while empty");
      check("empty_rd_o_ready", 32'(bus.o_ready_out), 32'd0);
      check("empty_rd_i_ready", 32'(bus.i_ready_out), 32'd1);

      // Wrap: write k and pop k-1 every cycle
      for (int k = 0; k < 10; k++) begin
         bus.i_data_in  = WIDTH'(k);
         bus.i_write_en = 1'b1;
         #1;
         if (k > 0) begin
            check("wrap_o_ready", 32'(bus.o_ready_out), 32'd1);
            check("wrap_data",    32'(bus.o_data_out),  32'(k - 1));
            $display("pair write %0d read %0h", k, bus.o_data_out);
         end else begin
            $display("pair write %0d read (empty)", k);
         end
         check("wrap_i_ready", 32'(bus.i_ready_out), 32'd1);
         tick();
      end
      bus.i_write_en = 1'b0;
      #1;
      check("wrap_last", 32'(bus.o_data_out), 32'd9);
      tick();
      $display("read 9");
      check("wrap_empty", 32'(bus.o_ready_out), 32'd0);
      bus.o_read_en = 1'b0;

      // Async reset mid-fill
      for (int i = 0; i < 2; i++) begin
         bus.i_data_in  = WIDTH'(i + 1);
         bus.i_write_en = 1'b1;
         tick();
         $display("write %0d", i + 1);
      end
      bus.i_write_en = 1'b0;
      check("mid_o_data", 32'(bus.o_data_out), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset asserted between edges");
      check("arst_o_ready", 32'(bus.o_ready_out), 32'd0);
      check("arst_i_ready", 32'(bus.i_ready_out), 32'd1);
      check("arst_o_data",  32'(bus.o_data_out),  32'd0);
      #1;
      rst_n = 1'b1;
      bus.i_data_in  = 4'h7;
      bus.i_write_en = 1'b1;
      tick();
      bus.i_write_en = 1'b0;
      $display("write 7 after reset");
      check("arst_head",       32'(bus.o_data_out),  32'h7);
      check("arst_head_valid", 32'(bus.o_ready_out), 32'd1);
      bus.o_read_en = 1'b1;
      tick();
      bus.o_read_en = 1'b0;
      $display("read 7");
      check("arst_final_empty", 32'(bus.o_ready_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
